pipe_stage_hs: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_hs.sv | 128 ++++++++++++
 tb/tb_pipe_stage_hs.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage.
//   pipe_state_t : how many payload entries the stage currently holds.
//   OCC_*        : occupancy values reported for each state.
//   occ_of()     : state -> occupancy decode.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   function automatic logic [1:0] occ_of(input pipe_state_t s);
      case (s)
         PS_ONE:  return OCC_ONE;
         PS_TWO:  return OCC_TWO;
         default: return OCC_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage statistics.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          inc,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (inc && (count_q != {CW{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with a two-entry skid buffer.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined;
// otherwise stall_count and flush_count are tied to zero.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high on that side. in_ready and occupancy depend only on the state register,
// so upstream sees a registered ready; the skid entry absorbs the beat that was
// already in flight when the downstream stalled.
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   flush                 : drop every held entry and any same-cycle input beat
//   in_valid/in_ready/in_data     : upstream side
//   out_valid/out_ready/out_data  : downstream side (out_data = NOP when idle)
//   occupancy             : held entries, 0..2 (exposes the FSM state)
//   stall_count/flush_count : saturating statistics
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int             N   = 32,
   parameter logic [N-1:0]   NOP = '0,
   parameter int             CW  = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [1:0]    occupancy,
   output logic [CW-1:0] stall_count,
   output logic [CW-1:0] flush_count
);

   pipe_state_t  state_q, state_d;
   logic [N-1:0] main_q, main_d;
   logic [N-1:0] skid_q, skid_d;
   logic         in_fire, out_fire;

   assign in_ready  = (state_q != PS_TWO);
   assign out_valid = (state_q != PS_EMPTY);
   assign occupancy = occ_of(state_q);
   // main is reloaded with NOP whenever the stage drains, so it can drive
   // the output directly.
   assign out_data  = main_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= PS_EMPTY;
         main_q  <= NOP;
         skid_q  <= NOP;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         PS_EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = PS_ONE;
            end
         end
         PS_ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = PS_TWO;
            end else if (out_fire) begin
               main_d  = NOP;
               state_d = PS_EMPTY;
            end
         end
         PS_TWO: begin
            // in_ready is low here, so only the drain side can move.
            if (out_fire) begin
               main_d  = skid_q;
               skid_d  = NOP;
               state_d = PS_ONE;
            end
         end
         default: begin
            state_d = PS_EMPTY;
            main_d  = NOP;
            skid_d  = NOP;
         end
      endcase
      // Squash wins over every handshake outcome above.
      if (flush) begin
         state_d = PS_EMPTY;
         main_d  = NOP;
         skid_d  = NOP;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   sat_counter #(.CW(CW)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .count (stall_count)
   );

   sat_counter #(.CW(CW)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (flush),
      .count (flush_count)
   );
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_pipe_stage_hs;

   localparam int           N   = 32;
   localparam int           CW  = 4;
   localparam logic [N-1:0] NOP = '0;
   localparam int           SAT = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Model: the held entries in order, oldest first, plus counter values.
   logic [N-1:0] exp_q[$];
   int           m_stall = 0;
   int           m_flush = 0;

   pipe_stage_hs #(.N(N), .NOP(NOP), .CW(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .occupancy   (occupancy),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: a FIFO of at most two entries.
   always @(posedge clock) begin : model
      int   sz;
      logic acc, drn;
      sz  = exp_q.size();
      acc = in_valid && (sz < 2);
      drn = (sz > 0) && out_ready;
      if (reset) begin
         exp_q.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         if ((sz > 0) && !out_ready && (m_stall < SAT)) m_stall++;
         if (flush && (m_flush < SAT)) m_flush++;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(in_data);
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clock) begin
      if (cmp_en) begin
         check("out_valid", out_valid, exp_q.size() > 0);
         check("out_data",  out_data,  (exp_q.size() > 0) ? exp_q[0] : NOP);
         check("in_ready",  in_ready,  exp_q.size() < 2);
         check("occupancy", occupancy, exp_q.size());
`ifdef PIPE_STAGE_STATS_EN
         check("stall_count", stall_count, m_stall);
         check("flush_count", flush_count, m_flush);
`else
         check("stall_count", stall_count, 0);
         check("flush_count", flush_count, 0);
`endif
      end
   end

   // driver: apply inputs for one rising edge, return 1 time unit after it
   task automatic step(input logic v, input logic [N-1:0] d, input logic r,
                       input logic f, input logic rst);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      reset     = rst;
      @(posedge clock);
      #1;
   endtask

   initial begin
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      cmp_en = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  NOP);
      check("rst_in_ready",  in_ready,  1);
      check("rst_occupancy", occupancy, 0);
      check("rst_stall",     stall_count, 0);
      check("rst_flush",     flush_count, 0);

      // Streaming at full rate.
      for (int i = 0; i < 8; i++) begin
         step(1, 32'hA0 + i, 1, 0, 0);
         check("stream_data", out_data, 32'hA0 + i);
         check("stream_ready", in_ready, 1);
         check("stream_occ", occupancy, 1);
      end
      step(0, '0, 1, 0, 0);
      check("stream_drain_valid", out_valid, 0);

      // Backpressure into the skid entry.
      step(1, 32'h11, 0, 0, 0);
      check("bp_occ1", occupancy, 1);
      step(1, 32'h22, 0, 0, 0);
      check("bp_occ2", occupancy, 2);
      check("bp_ready", in_ready, 0);
      check("bp_hold", out_data, 32'h11);
      step(0, '0, 1, 0, 0);
      check("bp_second", out_data, 32'h22);
      step(0, '0, 1, 0, 0);
      check("bp_empty_occ", occupancy, 0);
      check("bp_empty_nop", out_data, NOP);

      // Flush while full, with a same-cycle input beat.
      step(1, 32'h44, 0, 0, 0);
      step(1, 32'h55, 0, 0, 0);
      step(1, 32'h33, 0, 1, 0);
      check("fl_valid", out_valid, 0);
      check("fl_nop", out_data, NOP);
      check("fl_occ", occupancy, 0);
      step(0, '0, 1, 0, 0);
      check("fl_no_33", out_valid, 0);

      // Reset mid-stream.
      step(1, 32'h66, 0, 0, 0);
      step(1, 32'h77, 0, 0, 1);
      check("mr_valid", out_valid, 0);
      check("mr_nop", out_data, NOP);
      check("mr_occ", occupancy, 0);
      check("mr_ready", in_ready, 1);
      step(0, '0, 1, 0, 0);
      check("mr_no_stale", out_valid, 0);

      // Statistics saturation.
      step(1, 32'h88, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
`ifdef PIPE_STAGE_STATS_EN
      check("stall_sat", stall_count, 15);
`else
      check("stall_off", stall_count, 0);
`endif
      for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0);
`ifdef PIPE_STAGE_STATS_EN
      check("flush_cnt", flush_count, 3);
`else
      check("flush_off", flush_count, 0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
